// File: rtl/adpll_phase_detector_if.sv
// Phase-detector pin bundle: async clock inputs in, count instruction and status out.
// The master side drives the clocks; the detector sits on the slave side.
interface adpll_phase_detector_if #(parameter int WIDTH_BITS = 16);
   logic                  ref_clk_i;
   logic                  fb_clk_i;
   logic [1:0]            count_instr_o;
   logic [WIDTH_BITS-1:0] last_width_o;
   logic                  lock_o;

   modport master (output ref_clk_i, fb_clk_i,
                   input  count_instr_o, last_width_o, lock_o);
   modport slave  (input  ref_clk_i, fb_clk_i,
                   output count_instr_o, last_width_o, lock_o);
endinterface

// File: rtl/adpll_phase_detector.sv
// ADPLL phase-frequency detector: synchronizes ref/fb and emits UP/DOWN/DISABLE.
// Also measures error-pulse width and tracks lock.
module adpll_phase_detector #(
   parameter int SYNC_STAGES = 2,
   parameter int WIDTH_BITS  = 16,
   parameter int LOCK_TOL    = 4,
   parameter int LOCK_COUNT  = 8
) (
   input logic                  fpga_clk_i,
   input logic                  reset_n_i,
   adpll_phase_detector_if.slave pd
);
   localparam int HOLD = SYNC_STAGES + 1;
   localparam int HW   = $clog2(HOLD + 1);
   localparam int LW   = $clog2(LOCK_COUNT + 1);
   localparam logic [HW-1:0]         HOLD_V = HW'(HOLD);
   localparam logic [LW-1:0]         LC_MAX = LW'(LOCK_COUNT);
   localparam logic [WIDTH_BITS-1:0] TOL_V  = WIDTH_BITS'(LOCK_TOL);
   localparam logic [WIDTH_BITS-1:0] W_MAX  = '1;

   typedef enum logic [1:0] {IDLE = 2'b00, UP = 2'b01, DOWN = 2'b10} state_t;

   logic [SYNC_STAGES-1:0] ref_sync_q, ref_sync_d, fb_sync_q, fb_sync_d;
   logic                   ref_hist_q, fb_hist_q;
   logic                   ref_rise_q, ref_rise_d, fb_rise_q, fb_rise_d;
   logic [HW-1:0]          hold_q, hold_d;
   state_t                 state_q, state_d;
   logic [WIDTH_BITS-1:0]  width_q, width_d, last_q, last_d;
   logic [WIDTH_BITS-1:0]  width_inc, done_w;
   logic                   done;
   logic [LW-1:0]          lock_cnt_q, lock_cnt_d;
   logic                   lock_q, lock_d;

   // Rises are masked until the synchronizers have flushed after reset.
   always_comb begin
      ref_sync_d = {ref_sync_q[SYNC_STAGES-2:0], pd.ref_clk_i};
      fb_sync_d  = {fb_sync_q[SYNC_STAGES-2:0], pd.fb_clk_i};
      hold_d     = (hold_q == HOLD_V) ? hold_q : hold_q + 1'b1;
      ref_rise_d = ref_sync_q[SYNC_STAGES-1] & ~ref_hist_q & (hold_q == HOLD_V);
      fb_rise_d  = fb_sync_q[SYNC_STAGES-1] & ~fb_hist_q & (hold_q == HOLD_V);
   end

   always_comb begin
      state_d    = state_q;
      width_d    = width_q;
      last_d     = last_q;
      lock_cnt_d = lock_cnt_q;
      done       = 1'b0;
      done_w     = '0;
      width_inc  = (width_q == W_MAX) ? width_q : width_q + 1'b1;
      case (state_q)
         IDLE: begin
            if (ref_rise_q && fb_rise_q) begin
               done = 1'b1;
            end else if (ref_rise_q) begin
               state_d = UP;
               width_d = '0;
            end else if (fb_rise_q) begin
               state_d = DOWN;
               width_d = '0;
            end
         end
         UP: begin
            if (fb_rise_q) begin
               done    = 1'b1;
               done_w  = width_inc;
               width_d = '0;
               if (!ref_rise_q) state_d = IDLE;
            end else begin
               width_d = width_inc;
            end
         end
         DOWN: begin
            if (ref_rise_q) begin
               done    = 1'b1;
               done_w  = width_inc;
               width_d = '0;
               if (!fb_rise_q) state_d = IDLE;
            end else begin
               width_d = width_inc;
            end
         end
         default: state_d = IDLE;
      endcase
      if (done) begin
         last_d = done_w;
         if (done_w <= TOL_V)
            lock_cnt_d = (lock_cnt_q == LC_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
         else
            lock_cnt_d = '0;
      end
      lock_d = (lock_cnt_d == LC_MAX);
   end

   always_ff @(posedge fpga_clk_i) begin
      if (!reset_n_i) begin
         ref_sync_q <= '0;
         fb_sync_q  <= '0;
         ref_hist_q <= 1'b0;
         fb_hist_q  <= 1'b0;
         ref_rise_q <= 1'b0;
         fb_rise_q  <= 1'b0;
         hold_q     <= '0;
         state_q    <= IDLE;
         width_q    <= '0;
         last_q     <= '0;
         lock_cnt_q <= '0;
         lock_q     <= 1'b0;
      end else begin
         ref_sync_q <= ref_sync_d;
         fb_sync_q  <= fb_sync_d;
         ref_hist_q <= ref_sync_q[SYNC_STAGES-1];
         fb_hist_q  <= fb_sync_q[SYNC_STAGES-1];
         ref_rise_q <= ref_rise_d;
         fb_rise_q  <= fb_rise_d;
         hold_q     <= hold_d;
         state_q    <= state_d;
         width_q    <= width_d;
         last_q     <= last_d;
         lock_cnt_q <= lock_cnt_d;
         lock_q     <= lock_d;
      end
   end

   assign pd.count_instr_o = state_q;
   assign pd.last_width_o  = last_q;
   assign pd.lock_o        = lock_q;
endmodule
